// File: rtl/cpu_mem_pkg.sv
// Types and constants shared by the CPU data-memory port and its responder.
package cpu_mem_pkg;

  localparam int WORD_W = 32;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_ram_sp.sv
// Single-port word RAM: synchronous write, registered read with enable.
module mem_ram_sp
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  // contents are deliberately not reset so they survive a controller reset
  logic [WORD_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// CPU data-memory responder: accepts one request, inserts wait states, then
// strobes Memready (and Memerr on a bad access) for one cycle.
//
//   state    | meaning
//   MEM_IDLE | waiting for Memread/Memwrite; request is latched on accept
//   MEM_WAIT | counting wait states on the latched request, inputs ignored
//   MEM_DONE | one-cycle completion: Memready high, write commits on exit
module mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Memread,
  input  logic              Memwrite,
  input  logic [31:0]       Addr,
  input  logic [WORD_W-1:0] Memout,
  output logic [WORD_W-1:0] Memin,
  output logic              Memready,
  output logic              Memerr
);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $fatal(1, "mem_responder: WAIT_CYCLES must be 0..15");
  end
  if (ADDR_W < 1 || ADDR_W > 30) begin : g_bad_addr
    $fatal(1, "mem_responder: ADDR_W must be 1..30");
  end

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  mem_state_t        state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [31:0]       addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              op_q;
  logic              both_q;
  logic              rd_ok_q;

  logic              accept;
  logic              rd_load;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_rdata;

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> (ADDR_W + 2)) == 32'd0);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MEM_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    accept   = 1'b0;
    rd_load  = 1'b0;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    Memready = 1'b0;
    Memerr   = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (Memread || Memwrite) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            // zero-wait read must hit the RAM straight from the live inputs
            state_n = MEM_DONE;
            rd_load = !Memwrite;
            ram_re  = !Memwrite && addr_ok(Addr);
          end else begin
            state_n = MEM_WAIT;
            cnt_n   = WAIT_LOAD;
          end
        end
      end
      MEM_WAIT: begin
        if (cnt == 4'd0) begin
          state_n = MEM_DONE;
          rd_load = (op_q == OP_READ);
          ram_re  = (op_q == OP_READ) && addr_ok(addr_q);
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      MEM_DONE: begin
        Memready = 1'b1;
        Memerr   = both_q || !addr_ok(addr_q);
        ram_we   = (op_q == OP_WRITE) && addr_ok(addr_q);
        state_n  = MEM_IDLE;
      end
      default: state_n = MEM_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      op_q    <= OP_READ;
      both_q  <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= Addr;
        wdata_q <= Memout;
        op_q    <= Memwrite ? OP_WRITE : OP_READ;
        both_q  <= Memread && Memwrite;
      end
      if (rd_load) rd_ok_q <= ram_re;
    end
  end

  assign ram_addr = (state == MEM_IDLE) ? Addr[ADDR_W+1:2] : addr_q[ADDR_W+1:2];

  mem_ram_sp #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // RAM output register is unreset; a bad read or reset forces Memin to zero
  assign Memin = rd_ok_q ? ram_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 wait states and 0 wait states)
// checked against a word-array reference model.
module tb_mem_responder;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] wd;
  } op_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mr    [2];
  logic        mw    [2];
  logic [31:0] ad    [2];
  logic [31:0] mo    [2];
  logic [31:0] memin [2];
  logic        rdy   [2];
  logic        err   [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_m  [2][DEPTH];
  logic [31:0] last_m [2];

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .rst(rst), .Memread(mr[0]), .Memwrite(mw[0]), .Addr(ad[0]),
    .Memout(mo[0]), .Memin(memin[0]), .Memready(rdy[0]), .Memerr(err[0])
  );

  mem_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst), .Memread(mr[1]), .Memwrite(mw[1]), .Addr(ad[1]),
    .Memout(mo[1]), .Memin(memin[1]), .Memready(rdy[1]), .Memerr(err[1])
  );

  function automatic int waits(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Reference: byte address valid when word-aligned and below 4*DEPTH.
  function automatic void model_access(input int d, input bit rd, input bit wr,
                                       input logic [31:0] a, input logic [31:0] wd,
                                       output bit e, output logic [31:0] rv);
    bit valid;
    valid = (a % 4 == 0) && (a < 32'(4 * DEPTH));
    e = !valid || (rd && wr);
    if (wr) begin
      if (valid) mem_m[d][int'(a / 4)] = wd;
    end else begin
      last_m[d] = valid ? mem_m[d][int'(a / 4)] : 32'h0;
    end
    rv = last_m[d];
  endfunction

  task automatic do_access(input int d, input bit rd, input bit wr,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int lat, output logic e, output logic [31:0] rv,
                           output logic pulse1);
    @(negedge clk);
    mr[d] = rd; mw[d] = wr; ad[d] = a; mo[d] = wd;
    @(posedge clk); #1;
    mr[d] = 1'b0; mw[d] = 1'b0;
    lat = 0;
    while (rdy[d] !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    e  = err[d];
    rv = memin[d];
    @(posedge clk); #1;
    pulse1 = (rdy[d] === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      mr[d] = 1'b0; mw[d] = 1'b0; ad[d] = 32'h0; mo[d] = 32'h0; last_m[d] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++; if (memin[d] !== 32'h0) begin errors++; $display("FAIL reset_memin[%0d]: got %h expected 0", d, memin[d]); end
      checks++; if (rdy[d] !== 1'b0) begin errors++; $display("FAIL reset_ready[%0d]: got %b expected 0", d, rdy[d]); end
      checks++; if (err[d] !== 1'b0) begin errors++; $display("FAIL reset_err[%0d]: got %b expected 0", d, err[d]); end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    op_t ops [2] = '{'{1'b0, 1'b1, 32'h10, 32'hDEADBEEF}, '{1'b1, 1'b0, 32'h10, 32'h0}};
    int lat; logic e, p; logic [31:0] rv, ev; bit ee;
    foreach (ops[i]) begin
      do_access(0, ops[i].rd, ops[i].wr, ops[i].a, ops[i].wd, lat, e, rv, p);
      model_access(0, ops[i].rd, ops[i].wr, ops[i].a, ops[i].wd, ee, ev);
      checks++; if (lat !== 2) begin errors++; $display("FAIL wr_rd_latency[%0d]: got %0d expected 2", i, lat); end
      checks++; if (e !== ee) begin errors++; $display("FAIL wr_rd_err[%0d]: got %b expected %b", i, e, ee); end
      checks++; if (rv !== ev) begin errors++; $display("FAIL wr_rd_memin[%0d]: got %h expected %h", i, rv, ev); end
      checks++; if (p !== 1'b1) begin errors++; $display("FAIL wr_rd_pulse[%0d]: got %b expected 1", i, p); end
    end
  endtask

  task automatic test_zero_wait();
    op_t ops [3] = '{'{1'b0, 1'b1, 32'h0, 32'h8C010000}, '{1'b1, 1'b0, 32'h0, 32'h0},
                     '{1'b0, 1'b1, 32'h4, 32'h0BADF00D}};
    int lat; logic e, p; logic [31:0] rv, ev; bit ee;
    foreach (ops[i]) begin
      do_access(1, ops[i].rd, ops[i].wr, ops[i].a, ops[i].wd, lat, e, rv, p);
      model_access(1, ops[i].rd, ops[i].wr, ops[i].a, ops[i].wd, ee, ev);
      checks++; if (lat !== 0) begin errors++; $display("FAIL zw_latency[%0d]: got %0d expected 0", i, lat); end
      checks++; if (e !== ee) begin errors++; $display("FAIL zw_err[%0d]: got %b expected %b", i, e, ee); end
      checks++; if (rv !== ev) begin errors++; $display("FAIL zw_memin[%0d]: got %h expected %h", i, rv, ev); end
      checks++; if (p !== 1'b1) begin errors++; $display("FAIL zw_pulse[%0d]: got %b expected 1", i, p); end
    end
  endtask

  task automatic test_errors();
    op_t ops [7] = '{'{1'b0, 1'b1, 32'h13, 32'h55555555}, '{1'b1, 1'b0, 32'h10, 32'h0},
                     '{1'b1, 1'b0, 32'h00001000, 32'h0}, '{1'b0, 1'b1, 32'h00000FFC, 32'hCAFE0001},
                     '{1'b1, 1'b0, 32'h00000FFC, 32'h0}, '{1'b0, 1'b1, 32'h80000010, 32'h77777777},
                     '{1'b1, 1'b0, 32'h12, 32'h0}};
    int lat; logic e, p; logic [31:0] rv, ev; bit ee;
    foreach (ops[i]) begin
      do_access(0, ops[i].rd, ops[i].wr, ops[i].a, ops[i].wd, lat, e, rv, p);
      model_access(0, ops[i].rd, ops[i].wr, ops[i].a, ops[i].wd, ee, ev);
      checks++; if (lat !== 2) begin errors++; $display("FAIL bad_addr_latency[%0d]: got %0d expected 2", i, lat); end
      checks++; if (e !== ee) begin errors++; $display("FAIL bad_addr_err[%0d]: got %b expected %b", i, e, ee); end
      checks++; if (rv !== ev) begin errors++; $display("FAIL bad_addr_memin[%0d]: got %h expected %h", i, rv, ev); end
    end
    do_access(0, 1'b1, 1'b0, 32'h10, 32'h0, lat, e, rv, p);
    model_access(0, 1'b1, 1'b0, 32'h10, 32'h0, ee, ev);
    checks++; if (rv !== ev) begin errors++; $display("FAIL dropped_write_word10: got %h expected %h", rv, ev); end
  endtask

  task automatic test_both_requests();
    op_t ops [2] = '{'{1'b1, 1'b1, 32'h20, 32'h12345678}, '{1'b1, 1'b0, 32'h20, 32'h0}};
    int lat; logic e, p; logic [31:0] rv, ev; bit ee;
    foreach (ops[i]) begin
      do_access(0, ops[i].rd, ops[i].wr, ops[i].a, ops[i].wd, lat, e, rv, p);
      model_access(0, ops[i].rd, ops[i].wr, ops[i].a, ops[i].wd, ee, ev);
      checks++; if (e !== ee) begin errors++; $display("FAIL both_err[%0d]: got %b expected %b", i, e, ee); end
      checks++; if (rv !== ev) begin errors++; $display("FAIL both_memin[%0d]: got %h expected %h", i, rv, ev); end
    end
  endtask

  task automatic test_input_change();
    int lat; logic e, p; logic [31:0] rv, ev; bit ee;
    do_access(0, 1'b0, 1'b1, 32'h40, 32'h11111111, lat, e, rv, p);
    model_access(0, 1'b0, 1'b1, 32'h40, 32'h11111111, ee, ev);
    do_access(0, 1'b0, 1'b1, 32'h44, 32'h22222222, lat, e, rv, p);
    model_access(0, 1'b0, 1'b1, 32'h44, 32'h22222222, ee, ev);
    @(negedge clk);
    mr[0] = 1'b1; ad[0] = 32'h40;
    @(posedge clk); #1;
    ad[0] = 32'h44; mw[0] = 1'b1; mo[0] = 32'hFFFFFFFF;
    lat = 0;
    while (rdy[0] !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    model_access(0, 1'b1, 1'b0, 32'h40, 32'h0, ee, ev);
    checks++; if (lat !== 2) begin errors++; $display("FAIL chg_latency: got %0d expected 2", lat); end
    checks++; if (err[0] !== ee) begin errors++; $display("FAIL chg_err: got %b expected %b", err[0], ee); end
    checks++; if (memin[0] !== ev) begin errors++; $display("FAIL chg_memin: got %h expected %h", memin[0], ev); end
    mr[0] = 1'b0; mw[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (memin[0] !== ev) begin errors++; $display("FAIL chg_hold_idle: got %h expected %h", memin[0], ev); end
    do_access(0, 1'b0, 1'b1, 32'h48, 32'h33333333, lat, e, rv, p);
    model_access(0, 1'b0, 1'b1, 32'h48, 32'h33333333, ee, ev);
    checks++; if (rv !== ev) begin errors++; $display("FAIL chg_hold_write: got %h expected %h", rv, ev); end
    do_access(0, 1'b1, 1'b0, 32'h44, 32'h0, lat, e, rv, p);
    model_access(0, 1'b1, 1'b0, 32'h44, 32'h0, ee, ev);
    checks++; if (rv !== ev) begin errors++; $display("FAIL chg_word44: got %h expected %h", rv, ev); end
  endtask

  task automatic test_reset_mid();
    int lat; logic e, p; logic [31:0] rv, ev; bit ee; bit seen;
    do_access(0, 1'b0, 1'b1, 32'h30, 32'h0, lat, e, rv, p);
    model_access(0, 1'b0, 1'b1, 32'h30, 32'h0, ee, ev);
    @(negedge clk);
    mw[0] = 1'b1; ad[0] = 32'h30; mo[0] = 32'hAAAA5555;
    @(posedge clk); #1;
    mw[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    last_m[0] = 32'h0;
    last_m[1] = 32'h0;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rdy[0] === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b expected 0", seen); end
    checks++; if (memin[0] !== 32'h0) begin errors++; $display("FAIL rst_mid_memin: got %h expected 0", memin[0]); end
    do_access(0, 1'b1, 1'b0, 32'h30, 32'h0, lat, e, rv, p);
    model_access(0, 1'b1, 1'b0, 32'h30, 32'h0, ee, ev);
    checks++; if (rv !== ev) begin errors++; $display("FAIL rst_mid_word30: got %h expected %h", rv, ev); end
    checks++; if (e !== ee) begin errors++; $display("FAIL rst_mid_err: got %b expected %b", e, ee); end
  endtask

  task automatic test_random();
    int lat; logic e, p; logic [31:0] rv, ev, a, wd; bit ee, rd, wr;
    int wq [$];
    int kind;
    for (int d = 0; d < 2; d++) begin
      wq.delete();
      for (int n = 0; n < 40; n++) begin
        kind = $urandom_range(0, 9);
        wd = $urandom;
        if (wq.size() == 0 && kind >= 4 && kind <= 6) kind = 0;
        rd = 1'b0; wr = 1'b0;
        if (kind <= 3) begin
          wq.push_back($urandom_range(0, DEPTH - 1));
          a = 32'(wq[$] * 4); wr = 1'b1;
        end else if (kind <= 6) begin
          a = 32'(wq[$urandom_range(0, wq.size() - 1)] * 4); rd = 1'b1;
        end else if (kind == 7) begin
          a = ($urandom & 32'h00000FFC) | 32'($urandom_range(1, 3));
          rd = $urandom_range(0, 1) == 1; wr = !rd;
        end else if (kind == 8) begin
          a = ($urandom | 32'h00001000) & 32'hFFFFFFFC;
          rd = $urandom_range(0, 1) == 1; wr = !rd;
        end else begin
          wq.push_back($urandom_range(0, DEPTH - 1));
          a = 32'(wq[$] * 4); rd = 1'b1; wr = 1'b1;
        end
        do_access(d, rd, wr, a, wd, lat, e, rv, p);
        model_access(d, rd, wr, a, wd, ee, ev);
        checks++; if (lat !== waits(d)) begin errors++; $display("FAIL rnd_latency[%0d.%0d]: got %0d expected %0d", d, n, lat, waits(d)); end
        checks++; if (e !== ee) begin errors++; $display("FAIL rnd_err[%0d.%0d] addr %h: got %b expected %b", d, n, a, e, ee); end
        checks++; if (rv !== ev) begin errors++; $display("FAIL rnd_memin[%0d.%0d] addr %h: got %h expected %h", d, n, a, rv, ev); end
        checks++; if (p !== 1'b1) begin errors++; $display("FAIL rnd_pulse[%0d.%0d]: got %b expected 1", d, n, p); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_zero_wait();
    test_errors();
    test_both_requests();
    test_input_change();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
